// File: rtl/ledstring_rx_if.sv
// Output word channel of the LED string receiver: decoded fields plus valid/ready.
interface ledstring_rx_if #(
  parameter int unsigned IDX_W = 8
);
  logic             framing;
  logic             se_frame;
  logic [4:0]       dat_glo;
  logic [7:0]       dat_red;
  logic [7:0]       dat_grn;
  logic [7:0]       dat_blu;
  logic [IDX_W-1:0] led_idx;
  logic             valid;
  logic             ready;

  modport master (
    output framing, se_frame, dat_glo, dat_red, dat_grn, dat_blu, led_idx, valid,
    input  ready
  );

  modport slave (
    input  framing, se_frame, dat_glo, dat_red, dat_grn, dat_blu, led_idx, valid,
    output ready
  );
endinterface

// File: rtl/ledstring_rx.sv
// APA102-style string receiver: synchronises led_clk/led_data, assembles 32-bit
// words, classifies them and presents them through a one-entry output register.
module ledstring_rx #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned IDX_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_clk,
  input  logic             led_data,
  ledstring_rx_if.master   word_if,
  output logic             overflow,
  output logic             bad_frame
);

  typedef enum logic [1:0] {CLS_DATA, CLS_START, CLS_END, CLS_BAD} cls_e;

  logic             lclk_s1_q, lclk_s2_q, lclk_s3_q;
  logic             ldat_s1_q, ldat_s2_q;
  logic [31:0]      shift_q, shift_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      idle_q, idle_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             framing_q, framing_d;
  logic             se_q, se_d;
  logic [4:0]       glo_q, glo_d;
  logic [7:0]       red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic [IDX_W-1:0] oidx_q, oidx_d;
  logic             ovf_q, ovf_d;
  logic             bad_q, bad_d;
  logic             lclk_rise;
  cls_e             cls;

  always_comb begin
    lclk_rise = lclk_s2_q & ~lclk_s3_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    idle_d    = idle_q;
    done_d    = 1'b0;
    if (lclk_rise) begin
      shift_d   = {shift_q[30:0], ldat_s2_q};
      bit_cnt_d = bit_cnt_q + 5'd1;
      idle_d    = '0;
      done_d    = (bit_cnt_q == 5'd31);
    end else if (idle_q == 16'(TIMEOUT - 1)) begin
      // Saturated idle counter keeps the aligner cleared until the next edge.
      shift_d   = '0;
      bit_cnt_d = '0;
    end else begin
      idle_d    = idle_q + 16'd1;
    end
  end

  // shift_q cannot change in the cycle after completion, so it is classified directly.
  always_comb begin
    if (shift_q == '0)                 cls = CLS_START;
    else if (shift_q == '1)            cls = CLS_END;
    else if (shift_q[31:29] == 3'b111) cls = CLS_DATA;
    else                               cls = CLS_BAD;
  end

  always_comb begin
    valid_d   = valid_q & ~word_if.ready;
    framing_d = framing_q;
    se_d      = se_q;
    glo_d     = glo_q;
    red_d     = red_q;
    grn_d     = grn_q;
    blu_d     = blu_q;
    oidx_d    = oidx_q;
    idx_d     = idx_q;
    ovf_d     = 1'b0;
    bad_d     = 1'b0;
    if (done_q) begin
      if (cls == CLS_BAD) begin
        bad_d = 1'b1;
      end else begin
        if (cls == CLS_START) idx_d = '0;
        if (cls == CLS_DATA)  idx_d = idx_q + IDX_W'(1);
        if (valid_q && !word_if.ready) begin
          ovf_d = 1'b1;
        end else begin
          valid_d   = 1'b1;
          framing_d = (cls != CLS_DATA);
          se_d      = (cls == CLS_END);
          oidx_d    = (cls == CLS_DATA) ? idx_q : '0;
          unique case (cls)
            CLS_START: begin
              glo_d = '0; blu_d = '0; grn_d = '0; red_d = '0;
            end
            CLS_END: begin
              glo_d = '1; blu_d = '1; grn_d = '1; red_d = '1;
            end
            default: begin
              glo_d = shift_q[28:24];
              blu_d = shift_q[23:16];
              grn_d = shift_q[15:8];
              red_d = shift_q[7:0];
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lclk_s1_q <= 1'b0; lclk_s2_q <= 1'b0; lclk_s3_q <= 1'b0;
      ldat_s1_q <= 1'b0; ldat_s2_q <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      idle_q    <= '0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      framing_q <= 1'b0;
      se_q      <= 1'b0;
      glo_q     <= '0;
      red_q     <= '0;
      grn_q     <= '0;
      blu_q     <= '0;
      oidx_q    <= '0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      lclk_s1_q <= led_clk;   lclk_s2_q <= lclk_s1_q; lclk_s3_q <= lclk_s2_q;
      ldat_s1_q <= led_data;  ldat_s2_q <= ldat_s1_q;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      idle_q    <= idle_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      framing_q <= framing_d;
      se_q      <= se_d;
      glo_q     <= glo_d;
      red_q     <= red_d;
      grn_q     <= grn_d;
      blu_q     <= blu_d;
      oidx_q    <= oidx_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
    end
  end

  assign word_if.valid    = valid_q;
  assign word_if.framing  = framing_q;
  assign word_if.se_frame = se_q;
  assign word_if.dat_glo  = glo_q;
  assign word_if.dat_red  = red_q;
  assign word_if.dat_grn  = grn_q;
  assign word_if.dat_blu  = blu_q;
  assign word_if.led_idx  = oidx_q;
  assign overflow         = ovf_q;
  assign bad_frame        = bad_q;

endmodule
